alu_issue_stage: RTL and testbench

- Decode-to-execute pipeline stage that directly feeds the RV32 ALU.
- Takes a raw instruction, its PC and register-file read data, and produces the registered ALU operand pair, the 4-bit ALU control code and writeback info.
- Resolves operands, with forwarding from later stages, and holds them in a single-entry output register with valid/ready handshake and flush.

---
 rtl/rv32_pkg.sv | 40 ++++
 rtl/rv32_fwd_select.sv | 29 ++
 rtl/alu_issue_stage.sv | 116 +++++++++++
 tb/tb_alu_issue_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 opcode, ALU control and immediate helpers
package rv32_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // ALU control is {bit3, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        reg_we;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/rv32_fwd_select.sv
// rtl/rv32_fwd_select.sv - operand forwarding mux, EX/MEM over MEM/WB over regfile
module rv32_fwd_select #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic [4:0]      idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_we,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_value,
  input  logic            memwb_we,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_value,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = rf_data;
    if (ENABLE_FWD) begin
      if (idx == 5'd0)
        value = '0;
      else if (exmem_we && (exmem_rd == idx))
        value = exmem_value;
      else if (memwb_we && (memwb_rd == idx))
        value = memwb_value;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode/operand-resolve stage feeding the RV32 ALU
module alu_issue_stage
  import rv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            exmem_we,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_value,
  input  logic            memwb_we,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_value,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [2:0]      funct3;
  logic            accept;
  issue_t          dec;

  assign funct3   = instr[14:12];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  rv32_fwd_select #(.XLEN(XLEN), .ENABLE_FWD(ENABLE_FWD)) u_fwd_rs1 (
    .idx(instr[19:15]), .rf_data(rs1_data),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_value(exmem_value),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_value(memwb_value),
    .value(rs1_val)
  );

  rv32_fwd_select #(.XLEN(XLEN), .ENABLE_FWD(ENABLE_FWD)) u_fwd_rs2 (
    .idx(instr[24:20]), .rf_data(rs2_data),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_value(exmem_value),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_value(memwb_value),
    .value(rs2_val)
  );

  always_comb begin
    dec = '0;
    unique case (instr[6:0])
      OPC_OP: begin
        dec.a      = rs1_val;
        dec.b      = rs2_val;
        dec.ctrl   = {instr[30], funct3};
        dec.reg_we = 1'b1;
      end
      OPC_OPIMM: begin
        dec.a      = rs1_val;
        // shifts take the 5-bit shamt; only SRLI/SRAI carry bit 30 into ctrl
        dec.b      = (funct3 == F3_SLL || funct3 == F3_SR) ? {27'b0, instr[24:20]} : imm_i(instr);
        dec.ctrl   = {(funct3 == F3_SR) && instr[30], funct3};
        dec.reg_we = 1'b1;
      end
      OPC_LUI: begin
        dec.b      = imm_u(instr);
        dec.ctrl   = ALU_ADD;
        dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a      = pc;
        dec.b      = imm_u(instr);
        dec.ctrl   = ALU_ADD;
        dec.reg_we = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0)
      dec.reg_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      rd        <= '0;
      reg_we    <= 1'b0;
      pc_out    <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_a     <= dec.a;
      alu_b     <= dec.b;
      alu_ctrl  <= dec.ctrl;
      rd        <= instr[11:7];
      reg_we    <= dec.reg_we;
      pc_out    <= pc;
      illegal   <= dec.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and random checks against a reference model
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic        exmem_we = 1'b0, memwb_we = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_value = '0, memwb_value = '0;
  logic        flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] alu_a, alu_b, pc_out;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        reg_we, illegal;

  int total = 0;
  int bad = 0;
  bit was_rst = 1'b0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t held[$];

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_value(exmem_value),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_value(memwb_value),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd(rd),
    .reg_we(reg_we), .pc_out(pc_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (exmem_we && exmem_rd == idx) return exmem_value;
    if (memwb_we && memwb_rd == idx) return memwb_value;
    return rf;
  endfunction

  function automatic exp_t ref_issue();
    exp_t e;
    int f3;
    f3 = int'(instr[14:12]);
    e = '0;
    e.rd = instr[11:7];
    e.pc = pc;
    case (instr[6:0])
      7'h33: begin
        e.a = fwd(instr[19:15], rs1_data);
        e.b = fwd(instr[24:20], rs2_data);
        e.ctrl = {instr[30], 3'(f3)};
        e.we = 1'b1;
      end
      7'h13: begin
        e.a = fwd(instr[19:15], rs1_data);
        if (f3 == 1 || f3 == 5) e.b = (instr >> 20) & 32'd31;
        else e.b = $signed(instr) >>> 20;
        e.ctrl = (f3 == 5) ? {instr[30], 3'b101} : {1'b0, 3'(f3)};
        e.we = 1'b1;
      end
      7'h37: begin e.b = instr & 32'hFFFFF000; e.we = 1'b1; end
      7'h17: begin e.a = pc; e.b = instr & 32'hFFFFF000; e.we = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 0) e.we = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: check in_ready before the edge, advance the model, check outputs after it
  task automatic step();
    exp_t e;
    bit acc;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, (held.size() == 0) || out_ready});
    @(posedge clk);
    if (rst) begin
      held.delete();
      was_rst = 1'b1;
    end else begin
      acc = (held.size() == 0) || out_ready;
      if (held.size() != 0 && out_ready) void'(held.pop_front());
      if (flush) held.delete();
      else if (in_valid && acc) held.push_back(ref_issue());
      was_rst = 1'b0;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, 32'(held.size()));
    if (held.size() != 0) begin
      e = held[0];
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, e.ctrl});
      chk("rd", {27'b0, rd}, {27'b0, e.rd});
      chk("reg_we", {31'b0, reg_we}, {31'b0, e.we});
      chk("pc_out", pc_out, e.pc);
      chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
    end else if (was_rst) begin
      chk("rst_zero", {alu_a ^ alu_b ^ pc_out}, 32'd0);
      chk("rst_ctl", {22'b0, alu_ctrl, rd, reg_we}, 32'd0);
      chk("rst_ill", {31'b0, illegal}, 32'd0);
    end
  endtask

  task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2;
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] r, s1, s2;
    logic [2:0] f3;
    r = 5'($urandom_range(0, 4)); s1 = 5'($urandom_range(0, 4)); s2 = 5'($urandom_range(0, 4));
    f3 = 3'($urandom);
    case ($urandom_range(0, 5))
      0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, s2, s1, f3, r, 7'h33};
      1: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'(($urandom)), s2, s1, f3, r, 7'h13};
      2: return {20'($urandom), r, 7'h37};
      3: return {20'($urandom), r, 7'h17};
      4: return {25'($urandom), ($urandom_range(0, 1) != 0) ? 7'h73 : 7'h03};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    pc = 32'h0000_1000;
    step();
    rst = 1'b0;

    issue(1, 32'h002081B3, 5, 7);
    issue(1, 32'h402081B3, 5, 7);
    issue(1, 32'hFFF00293, 9, 9);
    issue(1, 32'h4030D213, 32'h8000_0000, 0);

    exmem_we = 1; exmem_rd = 1; exmem_value = 32'h100;
    memwb_we = 1; memwb_rd = 1; memwb_value = 32'h200;
    issue(1, 32'h002081B3, 5, 7);
    exmem_we = 0;
    issue(1, 32'h002081B3, 5, 7);
    exmem_we = 1; memwb_rd = 2;
    issue(1, 32'h002081B3, 5, 7);
    exmem_rd = 0; memwb_rd = 0;
    issue(1, 32'h000001B3, 5, 7);
    exmem_we = 0; memwb_we = 0;

    issue(1, 32'h00308233, 11, 22);
    out_ready = 0;
    issue(1, 32'h402081B3, 1, 2);
    issue(1, 32'h402081B3, 1, 2);
    issue(1, 32'h402081B3, 1, 2);
    out_ready = 1;
    issue(1, 32'h402081B3, 1, 2);
    issue(0, 32'h0, 0, 0);

    issue(1, 32'h002081B3, 3, 4);
    flush = 1;
    issue(0, 32'h002081B3, 3, 4);
    issue(1, 32'h00110113, 3, 4);
    flush = 0;
    issue(0, 0, 0, 0);

    issue(1, 32'h002081B3, 3, 4);
    out_ready = 0;
    issue(0, 0, 0, 0);
    rst = 1;
    issue(0, 0, 0, 0);
    rst = 0; out_ready = 1;

    issue(1, 32'h00000073, 8, 9);
    issue(1, 32'h00208033, 8, 9);
    issue(1, 32'h123452B7, 0, 0);
    pc = 32'h0000_2000;
    issue(1, 32'hABCDE317, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      flush = ($urandom_range(0, 12) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      exmem_we = 1'($urandom); exmem_rd = 5'($urandom_range(0, 4)); exmem_value = $urandom;
      memwb_we = 1'($urandom); memwb_rd = 5'($urandom_range(0, 4)); memwb_value = $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      issue(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
